// File: rtl/cdb_pkg.sv
// Shared Common Data Bus definitions: widths, tag encoding and the empty-operand marker.
package cdb_pkg;

  localparam int unsigned CDB_N_RS   = 4;
  localparam int unsigned CDB_DATA_W = 16;
  localparam int unsigned CDB_TAG_W  = 3;
  localparam int unsigned CDB_RDST_W = 3;

  // Tag 0 means "no producer"; station i broadcasts as tag i+1.
  localparam int unsigned TAG_NONE = 0;

  localparam logic [CDB_DATA_W-1:0] Vj_Vk_sem_valor = 16'hFFF0;

  function automatic int unsigned tag_of(input int unsigned idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after pointer, wrapping.
module rr_pick #(
  parameter int unsigned N_RS  = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_RS-1:0]  eligible,
  input  logic [PTR_W-1:0] pointer,
  output logic [N_RS-1:0]  winner,
  output logic [PTR_W-1:0] index,
  output logic             any
);

  int unsigned cand;

  always_comb begin
    winner = '0;
    index  = '0;
    any    = 1'b0;
    cand   = 0;
    for (int unsigned off = 0; off < N_RS; off++) begin
      cand = (32'(pointer) + off) % N_RS;
      if (!any && eligible[cand[PTR_W-1:0]]) begin
        any                       = 1'b1;
        index                     = cand[PTR_W-1:0];
        winner[cand[PTR_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one round-robin winner per cycle broadcasts tag/result/rdst
// and receives a registered one-cycle confirm pulse.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned N_RS   = CDB_N_RS,
  parameter int unsigned DATA_W = CDB_DATA_W,
  parameter int unsigned TAG_W  = CDB_TAG_W,
  parameter int unsigned RDST_W = CDB_RDST_W
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Flush,
  input  logic [N_RS-1:0]          Req,
  input  logic [N_RS*DATA_W-1:0]   Result_in,
  input  logic [N_RS*RDST_W-1:0]   Rdst_in,
  output logic [N_RS-1:0]          CDB_confirm,
  output logic                     CDB_valid,
  output logic [TAG_W-1:0]         CDB_tag,
  output logic [DATA_W-1:0]        CDB_data,
  output logic [RDST_W-1:0]        CDB_rdst,
  output logic [7:0]               Busy_cycles
);

  localparam int unsigned PTR_W = $clog2(N_RS);

  if (N_RS < 2 || N_RS > 7) begin : g_bad_n_rs
    $error("cdb_arbiter: N_RS must be in 2..7");
  end
  if (N_RS + 1 > (1 << TAG_W)) begin : g_bad_tag_w
    $error("cdb_arbiter: TAG_W too narrow for tag N_RS+1");
  end

  logic [PTR_W-1:0]  pointer;
  logic [N_RS-1:0]   mask;
  logic [N_RS-1:0]   eligible;
  logic [N_RS-1:0]   win_onehot;
  logic [PTR_W-1:0]  win_idx;
  logic              win_any;
  logic [PTR_W-1:0]  next_ptr;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;
  logic [RDST_W-1:0] win_rdst;
  logic              masked_only;

  // The last winner is masked for one arbitration so a station that still
  // holds Req in the cycle after its confirm is not granted twice.
  assign eligible = Req & ~mask;

  rr_pick #(
    .N_RS  (N_RS),
    .PTR_W (PTR_W)
  ) u_pick (
    .eligible (eligible),
    .pointer  (pointer),
    .winner   (win_onehot),
    .index    (win_idx),
    .any      (win_any)
  );

  always_comb begin
    win_data = '0;
    win_rdst = '0;
    for (int unsigned i = 0; i < N_RS; i++) begin
      if (win_onehot[i[PTR_W-1:0]]) begin
        win_data = Result_in[i*DATA_W +: DATA_W];
        win_rdst = Rdst_in[i*RDST_W +: RDST_W];
      end
    end
  end

  assign next_ptr    = (win_idx == PTR_W'(N_RS - 1)) ? '0 : win_idx + PTR_W'(1);
  assign win_tag     = TAG_W'(tag_of(32'(win_idx)));
  assign masked_only = (Req != '0) && !win_any;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      CDB_confirm <= '0;
      CDB_valid   <= 1'b0;
      CDB_tag     <= TAG_W'(TAG_NONE);
      CDB_data    <= '0;
      CDB_rdst    <= '0;
      Busy_cycles <= '0;
      pointer     <= '0;
      mask        <= '0;
    end else if (Flush) begin
      // Cancels any grant this edge; the station keeps Req and rearbitrates.
      CDB_confirm <= '0;
      CDB_valid   <= 1'b0;
      CDB_tag     <= TAG_W'(TAG_NONE);
      CDB_data    <= '0;
      CDB_rdst    <= '0;
      Busy_cycles <= '0;
      pointer     <= '0;
      mask        <= '0;
    end else if (win_any) begin
      CDB_confirm <= win_onehot;
      CDB_valid   <= 1'b1;
      CDB_tag     <= win_tag;
      CDB_data    <= win_data;
      CDB_rdst    <= win_rdst;
      pointer     <= next_ptr;
      mask        <= win_onehot;
    end else begin
      CDB_confirm <= '0;
      CDB_valid   <= 1'b0;
      CDB_tag     <= TAG_W'(TAG_NONE);
      mask        <= '0;
      if (masked_only && Busy_cycles != 8'hFF) begin
        Busy_cycles <= Busy_cycles + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: an independent cycle model predicts each edge's outputs.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] result_in = '0;
  logic [11:0] rdst_in = '0;

  logic [3:0]  confirm;
  logic        valid;
  logic [2:0]  tag;
  logic [15:0] data;
  logic [2:0]  rdst;
  logic [7:0]  busy;

  typedef struct packed {
    logic [3:0]  conf;
    logic        valid;
    logic [2:0]  tag;
    logic [15:0] data;
    logic [2:0]  rdst;
    logic [7:0]  busy;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  int          m_ptr;
  logic [3:0]  m_mask;
  int          m_busy;
  logic [15:0] m_data;
  logic [2:0]  m_rdst;
  int          last_grant;

  cdb_arbiter #(
    .N_RS   (4),
    .DATA_W (16),
    .TAG_W  (3),
    .RDST_W (3)
  ) dut (
    .Clock       (clk),
    .Reset       (rst_n),
    .Flush       (flush),
    .Req         (req),
    .Result_in   (result_in),
    .Rdst_in     (rdst_in),
    .CDB_confirm (confirm),
    .CDB_valid   (valid),
    .CDB_tag     (tag),
    .CDB_data    (data),
    .CDB_rdst    (rdst),
    .Busy_cycles (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  task automatic set_station(input int i, input logic [15:0] d, input logic [2:0] r);
    result_in[i*16 +: 16] = d;
    rdst_in[i*3 +: 3]     = r;
  endtask

  task automatic model_reset();
    m_ptr      = 0;
    m_mask     = '0;
    m_busy     = 0;
    m_data     = '0;
    m_rdst     = '0;
    last_grant = -1;
  endtask

  task automatic predict(output exp_t e);
    logic [3:0] elig;
    logic [1:0] j;
    int win;
    e    = '0;
    elig = req & ~m_mask;
    win  = -1;
    if (flush) begin
      model_reset();
    end else begin
      for (int k = 0; k < 4; k++) begin
        j = 2'(m_ptr + k);
        if (win < 0 && elig[j]) win = int'(j);
      end
      if (win >= 0) begin
        e.valid    = 1'b1;
        e.conf     = 4'b0001 << win;
        e.tag      = 3'(win + 1);
        m_data     = result_in[win*16 +: 16];
        m_rdst     = rdst_in[win*3 +: 3];
        m_ptr      = (win + 1) % 4;
        m_mask     = e.conf;
        last_grant = win;
      end else begin
        m_mask     = '0;
        last_grant = -1;
        if (req != 4'b0000 && m_busy < 255) m_busy++;
      end
      e.data = m_data;
      e.rdst = m_rdst;
      e.busy = 8'(m_busy);
    end
  endtask

  task automatic step(input string name);
    exp_t e;
    exp_t g;
    predict(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    check({name, " valid"},   32'(valid),   32'(g.valid));
    check({name, " confirm"}, 32'(confirm), 32'(g.conf));
    check({name, " tag"},     32'(tag),     32'(g.tag));
    check({name, " data"},    32'(data),    32'(g.data));
    check({name, " rdst"},    32'(rdst),    32'(g.rdst));
    check({name, " busy"},    32'(busy),    32'(g.busy));
  endtask

  task automatic check_zero(input string name);
    check({name, " valid"},   32'(valid),   32'd0);
    check({name, " confirm"}, 32'(confirm), 32'd0);
    check({name, " tag"},     32'(tag),     32'd0);
    check({name, " data"},    32'(data),    32'd0);
    check({name, " rdst"},    32'(rdst),    32'd0);
    check({name, " busy"},    32'(busy),    32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    for (int i = 0; i < 4; i++) set_station(i, 16'(16'h1000 + i), 3'(i + 1));

    // Reset held with all stations requesting
    req = 4'b1111;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_zero("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    step("t1 first");
    check("t1 tag1", 32'(tag), 32'd1);
    check("t1 conf0001", 32'(confirm), 32'h1);
    req = 4'b0000;
    step("t1 idle");

    // Single request, then held one extra cycle while masked
    set_station(2, 16'h00AB, 3'd5);
    req = 4'b0100;
    step("t2 grant");
    check("t2 tag3", 32'(tag), 32'd3);
    check("t2 data", 32'(data), 32'h00AB);
    check("t2 rdst", 32'(rdst), 32'd5);
    step("t2 masked");
    check("t2 masked valid", 32'(valid), 32'd0);
    check("t2 busy1", 32'(busy), 32'd1);
    req = 4'b0000;
    step("t2 idle");

    // Pointer now 3: station 3 first, then wrap to 0
    req = 4'b1001;
    step("t4 s3");
    check("t4 tag4", 32'(tag), 32'd4);
    step("t4 s0");
    check("t4 tag1", 32'(tag), 32'd1);
    req = 4'b0000;
    step("t4 idle");

    flush = 1'b1;
    step("flush");
    flush = 1'b0;

    // All request, each drops after its confirm
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step("t3 rr");
      check("t3 order tag", 32'(tag), 32'(k + 1));
      if (last_grant >= 0) req = req & ~(4'b0001 << last_grant);
    end
    step("t3 idle");

    // Flush cancels the in-flight regrant; station rearbitrates afterwards
    set_station(1, 16'h5A5A, 3'd2);
    req = 4'b0010;
    step("t5 grant");
    check("t5 tag2", 32'(tag), 32'd2);
    flush = 1'b1;
    step("t5 flush");
    check("t5 flush valid", 32'(valid), 32'd0);
    check("t5 flush data", 32'(data), 32'd0);
    flush = 1'b0;
    step("t5 regrant");
    check("t5 regrant tag", 32'(tag), 32'd2);
    check("t5 regrant data", 32'(data), 32'h5A5A);
    req = 4'b0000;
    step("t5 idle");

    // Random traffic: stations hold data until confirmed, some linger or withdraw
    for (int c = 0; c < 300; c++) begin
      flush = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          set_station(i, 16'($urandom), 3'($urandom));
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 29) == 0) begin
          req[i] = 1'b0;
        end
      end
      step("rand");
      if (last_grant >= 0 && $urandom_range(0, 1) == 0)
        req = req & ~(4'b0001 << last_grant);
    end
    flush = 1'b0;
    req = 4'b0000;
    step("rand drain");

    // Asynchronous reset in the middle of a broadcast
    req = 4'b0100;
    step("t6 grant");
    check("t6 valid before", 32'(valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 async valid", 32'(valid), 32'd0);
    check("t6 async confirm", 32'(confirm), 32'd0);
    check("t6 async tag", 32'(tag), 32'd0);
    check("t6 async data", 32'(data), 32'd0);
    req = 4'b0000;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("t6 release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
